// File: rtl/barrel_shifter_pkg.sv
// Shared types for the pipelined barrel shifter: operation encoding and
// the direction helper used by every stage.
package barrel_shifter_pkg;

  typedef enum logic [2:0] {
    SH_LSL = 3'd0,
    SH_LSR = 3'd1,
    SH_ASR = 3'd2,
    SH_ROL = 3'd3,
    SH_ROR = 3'd4
  } shift_mode_e;

  function automatic logic is_left(input logic [2:0] mode);
    return (mode == SH_LSL) || (mode == SH_ROL);
  endfunction

endpackage

// File: rtl/barrel_stage.sv
// One combinational shifter stage: moves the word by DIST when enabled and
// updates the running carry with the last bit that crossed the boundary.
module barrel_stage
  import barrel_shifter_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DIST  = 1
) (
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_en,
  input  logic [2:0]       i_mode,
  input  logic             i_carry,
  output logic [WIDTH-1:0] o_data,
  output logic             o_carry
);

  logic [WIDTH-1:0] w_lsl;
  logic [WIDTH-1:0] w_lsr;
  logic [WIDTH-1:0] w_asr;
  logic [WIDTH-1:0] w_rol;
  logic [WIDTH-1:0] w_ror;

  assign w_lsl = i_data << DIST;
  assign w_lsr = i_data >> DIST;
  assign w_asr = {{DIST{i_data[WIDTH-1]}}, i_data[WIDTH-1:DIST]};
  assign w_rol = {i_data[WIDTH-DIST-1:0], i_data[WIDTH-1:WIDTH-DIST]};
  assign w_ror = {i_data[DIST-1:0], i_data[WIDTH-1:DIST]};

  always_comb begin
    // NOTE: defaults first so every path assigns both outputs; otherwise a latch is inferred.
    o_data  = i_data;
    o_carry = i_carry;
    if (i_en) begin
      case (i_mode)
        SH_LSL:  o_data = w_lsl;
        SH_LSR:  o_data = w_lsr;
        SH_ASR:  o_data = w_asr;
        SH_ROL:  o_data = w_rol;
        SH_ROR:  o_data = w_ror;
        default: o_data = i_data;
      endcase
      // Reserved encodings act as a zero-distance move and leave carry alone.
      if (i_mode <= SH_ROR) begin
        o_carry = is_left(i_mode) ? i_data[WIDTH-DIST] : i_data[DIST-1];
      end
    end
  end

endmodule

// File: rtl/barrel_shifter_pipe.sv
// Pipelined shift/rotate unit: one register stage per shift-amount bit,
// valid/ready on both sides, a single global stall and no bubble squeezing.
// WIDTH must be a power of two and at least 2.
module barrel_shifter_pipe
  import barrel_shifter_pkg::*;
#(
  parameter  int WIDTH   = 8,
  localparam int SHAMT_W = $clog2(WIDTH)
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               i_valid,
  output logic               o_ready,
  input  logic [WIDTH-1:0]   i_data,
  input  logic [SHAMT_W-1:0] i_shift_amt,
  input  logic [2:0]         i_mode,
  output logic               o_valid,
  input  logic               i_ready,
  output logic [WIDTH-1:0]   o_shift_data,
  output logic               o_carry,
  output logic               o_zero
);

  // Index k is the input of stage k; index SHAMT_W is the pipeline output.
  logic [WIDTH-1:0]   w_data      [0:SHAMT_W];
  logic               w_valid     [0:SHAMT_W];
  logic               w_carry     [0:SHAMT_W];
  logic [2:0]         w_mode      [0:SHAMT_W-1];
  logic [SHAMT_W-1:0] w_amt       [0:SHAMT_W-1];
  logic [WIDTH-1:0]   w_nxt_data  [0:SHAMT_W-1];
  logic               w_nxt_carry [0:SHAMT_W-1];
  logic               w_stall;
  logic               r_zero;

  assign w_stall = w_valid[SHAMT_W] && !i_ready;
  assign o_ready = !w_stall;

  assign w_data[0]  = i_data;
  assign w_valid[0] = i_valid;
  assign w_carry[0] = 1'b0;
  assign w_mode[0]  = i_mode;
  assign w_amt[0]   = i_shift_amt;

  for (genvar k = 0; k < SHAMT_W; k++) begin : g_stage
    logic [WIDTH-1:0] r_data;
    logic             r_valid;
    logic             r_carry;

    // Amount is shifted down each stage, so bit 0 always enables the current move.
    barrel_stage #(
      .WIDTH (WIDTH),
      .DIST  (1 << k)
    ) u_stage (
      .i_data  (w_data[k]),
      .i_en    (w_amt[k][0]),
      .i_mode  (w_mode[k]),
      .i_carry (w_carry[k]),
      .o_data  (w_nxt_data[k]),
      .o_carry (w_nxt_carry[k])
    );

    // NOTE: non-blocking so every stage samples its neighbour's pre-edge value.
    always_ff @(posedge clk) begin
      if (!reset_n) begin
        r_valid <= 1'b0;
        r_data  <= '0;
        r_carry <= 1'b0;
      end else if (!w_stall) begin
        r_valid <= w_valid[k];
        r_data  <= w_nxt_data[k];
        r_carry <= w_nxt_carry[k];
      end
    end

    assign w_data[k+1]  = r_data;
    assign w_valid[k+1] = r_valid;
    assign w_carry[k+1] = r_carry;

    if (k < SHAMT_W - 1) begin : g_ctl
      logic [2:0]         r_mode;
      logic [SHAMT_W-1:0] r_amt;

      // NOTE: control travelling with the data is left unreset; the stage valid qualifies it.
      always_ff @(posedge clk) begin
        if (!w_stall) begin
          r_mode <= w_mode[k];
          r_amt  <= w_amt[k] >> 1;
        end
      end

      assign w_mode[k+1] = r_mode;
      assign w_amt[k+1]  = r_amt;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_zero <= 1'b0;
    end else if (!w_stall) begin
      r_zero <= (w_nxt_data[SHAMT_W-1] == '0);
    end
  end

  assign o_valid      = w_valid[SHAMT_W];
  assign o_shift_data = w_data[SHAMT_W];
  assign o_carry      = w_carry[SHAMT_W];
  assign o_zero       = r_zero;

endmodule
